// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: response sync pattern, serialiser state type and checksum helper
package uart_cmd_pkg;
  localparam logic [4:0] RESP_SYNC = 5'b10100;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;
  function automatic logic [7:0] resp_checksum(input logic [7:0] b);
    return ~b;
  endfunction
endpackage

// File: rtl/uart_resp_ser.sv
// uart_resp_ser: 8N1 byte serialiser; chains straight into the next byte when more_i is high at the stop bit end
module uart_resp_ser
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       more_i,
  input  logic [7:0] byte_i,
  output logic       data_o,
  output logic       busy_o,
  output logic       byte_done_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  ser_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic bit_end;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    bit_end     = cnt_q == CMAX;
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    byte_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (start_i) state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        byte_done_o = 1'b1;
        state_d     = more_i ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign data_o = state_q == START ? 1'b0 : state_q == DATA ? byte_i[idx_q] : 1'b1;
  assign busy_o = state_q != IDLE;
endmodule

// File: rtl/uart_cmd_resp.sv
// uart_cmd_resp: accepts a 3-bit command and echoes it as a UART response frame {RESP_SYNC, cmd}.
// Define UART_RESP_CHECKSUM_EN to append the inverted byte as a second byte of the frame.
module uart_cmd_resp
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] iCmd,
  input  logic       iCmdValid,
  output logic       oReady,
  output logic       oData,
  output logic       oBusy,
  output logic       oDone
);
  logic [2:0] cmd_q, cmd_d;
  logic live_q;
  logic accept, byte_done, more;
  logic [7:0] byte0, tx_byte;
  assign oReady = live_q && !oBusy;
  assign accept = iCmdValid && oReady;
  assign cmd_d  = accept ? iCmd : cmd_q;
  assign byte0  = {RESP_SYNC, cmd_q};
  assign oDone  = byte_done && !more;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= 1'b0;
      cmd_q  <= '0;
    end else begin
      live_q <= 1'b1;
      cmd_q  <= cmd_d;
    end
  end
`ifdef UART_RESP_CHECKSUM_EN
  logic sel_q;
  assign more    = !sel_q;
  assign tx_byte = sel_q ? resp_checksum(byte0) : byte0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= 1'b0;
    else if (byte_done) sel_q <= !sel_q;
  end
`else
  assign more    = 1'b0;
  assign tx_byte = byte0;
`endif
  uart_resp_ser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept),
    .more_i     (more),
    .byte_i     (tx_byte),
    .data_o     (oData),
    .busy_o     (oBusy),
    .byte_done_o(byte_done)
  );
endmodule

// File: tb/tb_uart_cmd_resp.sv
// tb_uart_cmd_resp: scoreboard bench; two instances (4 and 434 clocks per bit) checked by independent line receivers
module tb_uart_cmd_resp;
  localparam int SMALL = 4;
  localparam int BIG   = 434;
`ifdef UART_RESP_CHECKSUM_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  logic clk, rst;
  logic [2:0] cmd0, cmd1;
  logic [1:0] valid;
  wire  [1:0] ready, data, busy, done;
  int n_cmp, n_bad, cyc;
  int start_cyc[2], done_cyc[2], frames_rx[2], done_cnt[2], exp_frames[2], acc_cyc[2];
  logic [7:0] q0[$], q1[$];

  uart_cmd_resp #(.CLKS_PER_BIT(SMALL)) dut (
    .clk(clk), .rst(rst), .iCmd(cmd0), .iCmdValid(valid[0]),
    .oReady(ready[0]), .oData(data[0]), .oBusy(busy[0]), .oDone(done[0]));
  uart_cmd_resp #(.CLKS_PER_BIT(BIG)) dut_big (
    .clk(clk), .rst(rst), .iCmd(cmd1), .iCmdValid(valid[1]),
    .oReady(ready[1]), .oData(data[1]), .oBusy(busy[1]), .oDone(done[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int k = 0; k < 2; k++) if (!rst && done[k]) done_cnt[k]++;

  task automatic chk(input logic ok, input string name, input int act, input int req);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    return k ? q1.size() : q0.size();
  endfunction
  function automatic logic [7:0] pop(input int k);
    return k ? q1.pop_front() : q0.pop_front();
  endfunction
  function automatic void push(input int k, input logic [7:0] b);
    if (k) q1.push_back(b);
    else q0.push_back(b);
  endfunction
  function automatic void push_frame(input int k, input logic [2:0] c);
    logic [7:0] b0;
    b0 = 8'hA0 + 8'(c);
    push(k, b0);
    if (NB == 2) push(k, 8'hFF - b0);
    exp_frames[k]++;
  endfunction

  task automatic monitor(input int k);
    int cpb;
    cpb = k ? BIG : SMALL;
    forever begin
      @(negedge clk);
      if (!rst && data[k] === 1'b0) begin
        logic abort;
        abort = 0;
        start_cyc[k] = cyc;
        for (int b = 0; b < NB; b++) begin
          logic [9:0] bits;
          logic stable, busy_ok, done_ok, have;
          logic [7:0] exp;
          if (abort) break;
          have = qsize(k) != 0;
          chk(have, "frame_expected", 0, 1);
          exp = have ? pop(k) : 8'h00;
          bits = '0;
          stable = 1;
          busy_ok = 1;
          done_ok = 1;
          for (int i = 0; i < 10 * cpb; i++) begin
            if (b > 0 || i > 0) @(negedge clk);
            if (rst) begin
              abort = 1;
              break;
            end
            if (i % cpb == 0) bits[i/cpb] = data[k];
            else if (data[k] !== bits[i/cpb]) stable = 0;
            if (busy[k] !== 1'b1) busy_ok = 0;
            if (done[k] !== (b == NB - 1 && i == 10 * cpb - 1)) done_ok = 0;
          end
          if (!abort) begin
            chk(bits[8:1] === exp, "byte", bits[8:1], exp);
            chk(bits[0] === 1'b0 && bits[9] === 1'b1, "framing", bits, 10'h200 | (exp << 1));
            chk(stable, "bit_width", stable, 1);
            chk(busy_ok, "busy_in_frame", busy_ok, 1);
            chk(done_ok, "done_timing", done_ok, 1);
          end
        end
        if (!abort) begin
          done_cyc[k] = cyc;
          @(negedge clk);
          chk(rst || (busy[k] === 1'b0 && data[k] === 1'b1), "idle_after_done", {busy[k], data[k]}, 1);
          frames_rx[k]++;
        end
      end
    end
  endtask
  initial monitor(0);
  initial monitor(1);

  task automatic send(input int k, input logic [2:0] c);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (ready[k] !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(ready[k], "ready_wait", ready[k], 1);
    if (k) cmd1 = c;
    else cmd0 = c;
    valid[k] = 1;
    push_frame(k, c);
    @(posedge clk); #1;
    acc_cyc[k] = cyc;
    valid[k] = 0;
    if (k) cmd1 = 3'($urandom);
    else cmd0 = 3'($urandom);
  endtask

  task automatic wait_frames(input int k, input int n, input int lim);
    int t;
    t = 0;
    while (frames_rx[k] < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk(frames_rx[k] >= n, "frame_timeout", frames_rx[k], n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, prev_done;
    rst = 1;
    valid = 0;
    cmd0 = 0;
    cmd1 = 0;
    repeat (3) @(negedge clk);
    chk(ready === 2'b00 && data === 2'b11 && busy === 2'b00 && done === 2'b00, "reset_outputs",
        {ready, data, busy, done}, 8'h30);
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    chk(ready === 2'b00, "ready_before_edge", ready, 0);
    @(negedge clk);
    chk(ready === 2'b11, "ready_after_reset", ready, 3);
    // single command 7, start bit in the cycle after acceptance
    send(0, 3'd7);
    wait_frames(0, 1, 200);
    chk(start_cyc[0] == acc_cyc[0], "start_latency", start_cyc[0] - acc_cyc[0], 0);
    chk(done_cyc[0] - start_cyc[0] == 10 * SMALL * NB - 1, "frame_length",
        done_cyc[0] - start_cyc[0] + 1, 10 * SMALL * NB);
    // valid held high, iCmd changed mid-frame
    @(posedge clk); #1;
    base = frames_rx[0];
    cmd0 = 3'd2;
    valid[0] = 1;
    push_frame(0, 3'd2);
    repeat (15) @(posedge clk);
    #1;
    cmd0 = 3'd5;
    push_frame(0, 3'd5);
    wait_frames(0, base + 1, 200);
    prev_done = done_cyc[0];
    @(posedge clk); #1;
    valid[0] = 0;
    wait_frames(0, base + 2, 200);
    chk(start_cyc[0] - prev_done == 2, "back_to_back_gap", start_cyc[0] - prev_done, 2);
    // pulse while busy is ignored
    base = frames_rx[0];
    send(0, 3'd4);
    repeat (12) @(posedge clk);
    #1;
    chk(busy[0] === 1'b1 && ready[0] === 1'b0, "busy_not_ready", {busy[0], ready[0]}, 2);
    cmd0 = 3'd6;
    valid[0] = 1;
    @(posedge clk); #1;
    valid[0] = 0;
    wait_frames(0, base + 1, 200);
    repeat (30) @(negedge clk);
    chk(frames_rx[0] == base + 1, "ignored_pulse", frames_rx[0] - base, 1);
    // randomized commands with random gaps
    for (int i = 0; i < 8; i++) begin
      send(0, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_frames(0, exp_frames[0], 2000);
    // reset in the middle of byte0 data bits
    send(0, 3'd1);
    while (cyc < acc_cyc[0] + 3 * SMALL) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk(data === 2'b11 && busy === 2'b00 && done === 2'b00 && ready === 2'b00, "async_reset",
        {ready, data, busy, done}, 8'h30);
    exp_frames[0]--;
    repeat (2) @(negedge clk);
    q0.delete();
    @(posedge clk); #2;
    rst = 0;
    send(0, 3'd0);
    wait_frames(0, exp_frames[0], 200);
    chk(start_cyc[0] == acc_cyc[0], "start_after_reset", start_cyc[0] - acc_cyc[0], 0);
    // long bit time instance
    send(1, 3'd3);
    wait_frames(1, 1, 12000);
    chk(done_cyc[1] - start_cyc[1] == 10 * BIG * NB - 1, "big_frame_length",
        done_cyc[1] - start_cyc[1] + 1, 10 * BIG * NB);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(done_cnt[k] == exp_frames[k], "done_count", done_cnt[k], exp_frames[k]);
      chk(frames_rx[k] == exp_frames[k], "frame_count", frames_rx[k], exp_frames[k]);
      chk(qsize(k) == 0, "queue_empty", qsize(k), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_resp.md
UART_CMD_RESP -- requirements
Module: uart_cmd_resp

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iCmd  input  3  command code to echo as a response frame.
REQ-005 SHALL have port iCmdValid  input  1  iCmd is valid this cycle.
REQ-006 SHALL have port oReady  output  1  block can accept a command this cycle.
REQ-007 SHALL have port oData  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port oBusy  output  1  a frame is being shifted out.
REQ-009 SHALL have port oDone  output  1  one-cycle pulse at the end of a frame.

Function
REQ-010 SHALL accept a command on a rising edge where iCmdValid=1 and oReady=1, and SHALL latch iCmd on that edge.
REQ-011 SHALL ignore iCmdValid while oReady=0, with no queuing; SHALL ignore iCmd changes after acceptance.
REQ-012 SHALL form response byte0 = {RESP_SYNC, cmd}, where RESP_SYNC = 5'b10100 (cmd 7 -> 0xA7).
REQ-013 SHALL serialise each byte as start bit (0), 8 data bits LSB first, then stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-014 SHALL drive the start bit of byte0 from the cycle after acceptance; oBusy SHALL be high from that cycle until oDone.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->STOP after the 8th bit; STOP->START if another byte is pending, else STOP->IDLE.
REQ-016 SHALL transmit consecutive bytes of one frame with no idle gap: the next start bit follows the previous stop bit directly.
REQ-017 SHALL pulse oDone for exactly one cycle on the last cycle of the final stop bit; the FSM SHALL be in IDLE on the next cycle.
REQ-018 SHALL assert oReady only in IDLE, so a back-to-back command is accepted at the earliest on the cycle after oDone.
REQ-019 SHALL keep oData=1 whenever in IDLE.
REQ-020 SHALL use a bit-timing counter wide enough for CLKS_PER_BIT-1 and a 3-bit bit index; both SHALL reset to 0 at each bit or byte boundary.

Reset
REQ-021 SHALL, while rst=1 (asynchronously), force state IDLE, oData=1, oBusy=0, oDone=0, oReady=0, and clear counters and the latched command.
REQ-022 SHALL drive oReady=1 from the first clock edge after rst deasserts.
REQ-023 SHALL abort a frame in progress on reset mid-frame, with no oDone for the aborted frame.

Configuration
REQ-024 SHALL honour macro UART_RESP_CHECKSUM_EN.
- Defined: the frame is byte0 then byte1 = ~byte0 (0xA7 -> 0x58), and oDone follows byte1 (20*CLKS_PER_BIT cycles of line activity).
- Undefined: the frame is byte0 only (10*CLKS_PER_BIT cycles), and no checksum logic is present.

Structure
REQ-025 SHALL take RESP_SYNC, the FSM state enum type, and the checksum function from package uart_cmd_pkg.
REQ-026 SHALL place the byte serialiser (START/DATA/STOP timing, byte in, byte-done out) in sub-module uart_resp_ser; the top SHALL hold the handshake, command latch, and byte sequencing.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-027 SHALL verify: reset, then iCmd=7 with iCmdValid pulsed 1 cycle -> oData shows 0,1,1,1,0,0,1,0,1,1 (4 cycles each), byte decodes as 0xA7, and oDone fires 40 cycles after the start bit begins (checksum off).
REQ-028 SHALL verify with UART_RESP_CHECKSUM_EN: iCmd=7 -> bytes 0xA7 then 0x58 with no gap, and a single oDone 80 cycles after the start bit begins.
REQ-029 SHALL verify: iCmd=2, then iCmdValid held high with iCmd toggling to 5 mid-frame -> first frame is 0xA2; second frame is accepted on the cycle after oDone and carries the iCmd present at that edge.
REQ-030 SHALL verify: rst asserted mid-DATA of byte0 -> oData=1, oBusy=0, oDone=0 immediately, without a clock edge; after release, iCmd=0 transmits 0xA0 correctly.
REQ-031 SHALL verify at CLKS_PER_BIT=434: iCmd=3 decoded by an independent bench receiver -> 0xA3, and each bit width is exactly 434 cycles.
REQ-032 SHALL verify: iCmdValid pulsed while oBusy=1 -> pulse ignored, exactly one frame sent, and no extra oDone.
